gray_code_conv_pipe: RTL and testbench

Parametrised successor to the 4-bit binary-to-Gray converter. It converts WIDTH-bit words between binary and reflected Gray code, with the mode selectable per word.
- Clocked, with valid/ready handshakes on input and output.
- Two-entry output buffer (skid), so the block sustains one word per clock under backpressure.
- Sits between a producer (counter, encoder interface, CDC pointer logic) and any consumer.

---
 rtl/gray_code_conv_pipe.sv | 145 ++++++++++++++
 tb/tb_gray_code_conv_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_conv_pipe.sv
// Per-word binary<->Gray converter feeding a two-entry (main + skid) output buffer.
// Define GRAY_CODE_CONV_PARITY_EN to add a buffered out_parity output.
module gray_code_conv_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
`ifdef GRAY_CODE_CONV_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [1:0] MODE_B2G  = 2'b00;
  localparam logic [1:0] MODE_G2B  = 2'b01;
  localparam logic [1:0] MODE_PASS = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
`ifdef GRAY_CODE_CONV_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           conv;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Conversion of the word presented this cycle.
  always_comb begin
    conv = '0;
    case (in_mode)
      MODE_B2G:  conv.data = bin2gray(in_data);
      MODE_G2B:  conv.data = gray2bin(in_data);
      MODE_PASS: conv.data = in_data;
      default:   conv.err  = 1'b1;
    endcase
`ifdef GRAY_CODE_CONV_PARITY_EN
    conv.parity = ^conv.data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Buffer occupancy FSM; main always holds the oldest word.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = conv;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = conv;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = conv;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    cnt_d       = in_xfer ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = main_q.data;
  assign out_err    = main_q.err;
`ifdef GRAY_CODE_CONV_PARITY_EN
  assign out_parity = main_q.parity;
`endif
  assign xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_gray_code_conv_pipe.sv
// Bench for gray_code_conv_pipe: vector table, hand sequences and random traffic vs a queue model.
module tb_gray_code_conv_pipe;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    in_mode;
  logic [15:0]   xfer_cnt;

  logic          w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_out_err;
  logic [7:0]    w8_in_data, w8_out_data;
  logic [1:0]    w8_in_mode;
  logic [3:0]    w8_xfer_cnt;
`ifdef GRAY_CODE_CONV_PARITY_EN
  logic          out_parity, w8_out_parity;
`endif

  gray_code_conv_pipe #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
`ifdef GRAY_CODE_CONV_PARITY_EN
    .out_parity(out_parity),
`endif
    .xfer_cnt(xfer_cnt)
  );

  gray_code_conv_pipe #(.WIDTH(8), .CNT_W(4)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_data(w8_in_data), .in_mode(w8_in_mode),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_data(w8_out_data),
    .out_err(w8_out_err),
`ifdef GRAY_CODE_CONV_PARITY_EN
    .out_parity(w8_out_parity),
`endif
    .xfer_cnt(w8_xfer_cnt)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] din;
    logic [W-1:0] dexp;
    logic         eexp;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cnt_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion; Gray->binary found by searching for the code's preimage.
  function automatic exp_t ref_conv(input logic [W-1:0] d, input logic [1:0] m);
    exp_t r;
    r.d = d;
    r.e = 1'b0;
    case (m)
      2'b00: r.d = d ^ (d >> 1);
      2'b01: begin
        for (int v = 0; v < 16; v++) begin
          if ((4'(v) ^ (4'(v) >> 1)) == d) r.d = 4'(v);
        end
      end
      2'b10: r.d = d;
      default: begin
        r.d = '0;
        r.e = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic check_state();
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("xfer_cnt", 32'(xfer_cnt), 32'(cnt_exp[15:0]));
    if (q.size() > 0) begin
      check("out_data", 32'(out_data), 32'(q[0].d));
      check("out_err", 32'(out_err), 32'(q[0].e));
`ifdef GRAY_CODE_CONV_PARITY_EN
      check("out_parity", 32'(out_parity), 32'($countones(q[0].d) % 2));
`endif
    end
  endtask

  // One clock: observe handshakes before the edge, update the model, check after.
  task automatic cycle(input exp_t pushv, output bit acc);
    bit ix, ox;
    ix = (in_valid === 1'b1) && (in_ready === 1'b1);
    ox = (out_valid === 1'b1) && (out_ready === 1'b1);
    @(posedge clk);
    #1;
    if (ox && q.size() > 0) void'(q.pop_front());
    if (ix) begin
      q.push_back(pushv);
      cnt_exp++;
    end
    acc = ix;
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 4'hF;
    in_mode     = 2'b00;
    out_ready   = 1'b1;
    w8_in_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    w8_in_valid = 1'b0;
    q.delete();
    cnt_exp = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_w8_xfer_cnt", 32'(w8_xfer_cnt), 32'd0);
    check("rst_w8_out_valid", 32'(w8_out_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[20];
    logic [W-1:0] gexp[16];
    logic [W-1:0] bp[5];
    exp_t         ev;
    bit           acc;
    bit           held;
    int           k;
    logic [W-1:0] rd;
    logic [1:0]   rm;

    gexp = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    for (int i = 0; i < 16; i++) tbl[i] = '{2'b00, 4'(i), gexp[i], 1'b0};
    tbl[16] = '{2'b01, 4'b1101, 4'b1001, 1'b0};
    tbl[17] = '{2'b11, 4'hA, 4'h0, 1'b1};
    tbl[18] = '{2'b00, 4'h5, 4'h7, 1'b0};
    tbl[19] = '{2'b10, 4'hC, 4'hC, 1'b0};
    bp = '{4'd3, 4'd9, 4'd14, 4'd6, 4'd1};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_mode      = '0;
    out_ready    = 1'b1;
    w8_in_valid  = 1'b0;
    w8_in_data   = '0;
    w8_in_mode   = '0;
    w8_out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high; nothing may be accepted.
    do_reset(3);
    ev = '{4'h0, 1'b0};
    cycle(ev, acc);

    // Vector table, streaming with out_ready high.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].din;
      in_mode  = tbl[i].mode;
      ev       = '{tbl[i].dexp, tbl[i].eexp};
      acc      = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) cycle(ev, acc);
      if (!acc) check("tbl_accept", 32'd0, 32'd1);
      if (i == 15) check("cnt_after_16", 32'(xfer_cnt), 32'd16);
    end
    in_valid = 1'b0;
    repeat (3) cycle(ev, acc);

    // Backpressure: only two words fit while out_ready is low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    k = 0;
    for (int t = 0; t < 4; t++) begin
      in_data = bp[k];
      cycle(ref_conv(bp[k], 2'b00), acc);
      if (acc) k++;
    end
    check("bp_accepted", 32'(k), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int t = 0; t < 20 && (k < 5 || q.size() > 0); t++) begin
      in_valid = (k < 5);
      in_data  = bp[(k < 5) ? k : 0];
      cycle(ref_conv(in_data, 2'b00), acc);
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("bp_drained", 32'(q.size()), 32'd0);
    check("bp_total", 32'(k), 32'd5);

    // Reset with a full buffer drops both words.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h6;
    cycle(ref_conv(4'h6, 2'b00), acc);
    in_data   = 4'h2;
    cycle(ref_conv(4'h2, 2'b00), acc);
    check("mid_full", 32'(in_ready), 32'd0);
    do_reset(1);
    out_ready = 1'b1;
    cycle(ev, acc);

    // Random traffic; a refused word is held until accepted.
    held = 1'b0;
    rd   = '0;
    rm   = '0;
    for (int t = 0; t < 600; t++) begin
      if (!held) begin
        rd       = 4'($urandom);
        rm       = 2'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      in_data   = rd;
      in_mode   = rm;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(ref_conv(rd, rm), acc);
      held = in_valid && !acc;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle(ev, acc);

    // WIDTH=8, CNT_W=4 instance: Gray->binary of 8'hFF, and counter wrap after 17 words.
    w8_out_ready = 1'b1;
    w8_in_valid  = 1'b1;
    w8_in_mode   = 2'b01;
    w8_in_data   = 8'hFF;
    for (int t = 0; t < 17; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        check("w8_out_valid", 32'(w8_out_valid), 32'd1);
        check("w8_g2b_ff", 32'(w8_out_data), 32'hAA);
        check("w8_out_err", 32'(w8_out_err), 32'd0);
`ifdef GRAY_CODE_CONV_PARITY_EN
        check("w8_parity", 32'(w8_out_parity), 32'd0);
`endif
      end
    end
    w8_in_valid = 1'b0;
    check("w8_cnt_wrap", 32'(w8_xfer_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
